// File: rtl/sram_bus_pkg.sv
// Shared definitions for the SRAM-style request bus: default field widths
// and the arbiter FSM state encoding.
package sram_bus_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 256;
  localparam int SB_TYPE_W = 6;
  localparam int SB_STRB_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_ADDR = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR      = 2'd3
  } sb_state_e;

endpackage

// File: rtl/sram_bus_arbiter_n_rr_pick.sv
// Request picker: lowest index in fixed mode, first requester at or after
// ptr (cyclic) in round-robin mode.
module rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             rr_mode,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int               base;
    int               cand;
    logic [IDX_W-1:0] c_idx;
    idx = '0;
    any = |req;
    base = rr_mode ? int'(ptr) : 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand  = ((base + k) >= N) ? (base + k - N) : (base + k);
      c_idx = cand[IDX_W-1:0];
      if (req[c_idx]) begin
        idx = c_idx;
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/sram_bus_arbiter_n.sv
// N-master to one-slave arbiter for the SRAM-style request bus. One
// transaction outstanding; a granted master's write is served before its read.
module sram_bus_arbiter_n
  import sram_bus_pkg::*;
#(
  parameter int NUM_M   = 3,
  parameter int ADDR_W  = SB_ADDR_W,
  parameter int DATA_W  = SB_DATA_W,
  parameter int TYPE_W  = SB_TYPE_W,
  parameter int STRB_W  = SB_STRB_W,
  parameter int RR_MODE = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_M-1:0]           m_r_req,
  input  logic [NUM_M*ADDR_W-1:0]    m_r_addr,
  input  logic [NUM_M*TYPE_W-1:0]    m_r_type,
  output logic [NUM_M-1:0]           m_r_rdy,
  output logic [NUM_M-1:0]           m_re_valid,
  output logic [DATA_W-1:0]          m_re_data,
  input  logic [NUM_M-1:0]           m_w_req,
  input  logic [NUM_M*ADDR_W-1:0]    m_w_addr,
  input  logic [NUM_M*DATA_W-1:0]    m_w_data,
  input  logic [NUM_M*TYPE_W-1:0]    m_w_type,
  input  logic [NUM_M*STRB_W-1:0]    m_w_strb,
  output logic [NUM_M-1:0]           m_w_rdy,
  output logic                       s_r_req,
  output logic [ADDR_W-1:0]          s_r_addr,
  output logic [TYPE_W-1:0]          s_r_type,
  input  logic                       s_r_rdy,
  input  logic                       s_re_valid,
  input  logic [DATA_W-1:0]          s_re_data,
  output logic                       s_w_req,
  output logic [ADDR_W-1:0]          s_w_addr,
  output logic [DATA_W-1:0]          s_w_data,
  output logic [TYPE_W-1:0]          s_w_type,
  output logic [STRB_W-1:0]          s_w_strb,
  input  logic                       s_w_rdy
);

  localparam int   IDX_W = $clog2(NUM_M);
  localparam logic RR_EN = (RR_MODE != 0);

  sb_state_e        state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] ptr_next_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic             pick_any_s;
  logic [NUM_M-1:0] req_any_s;
  logic             rd_addr_s, rd_data_s, wr_s;

  assign req_any_s  = m_r_req | m_w_req;
  assign ptr_next_s = (gnt_q == IDX_W'(NUM_M - 1)) ? '0 : (gnt_q + IDX_W'(1));

  rr_pick #(.N(NUM_M), .IDX_W(IDX_W)) u_pick (
    .req     (req_any_s),
    .ptr     (ptr_q),
    .rr_mode (RR_EN),
    .idx     (pick_idx_s),
    .any     (pick_any_s)
  );

  // Next-state, grant capture and round-robin pointer advance on completion.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          gnt_d   = pick_idx_s;
          state_d = m_w_req[pick_idx_s] ? ST_WR : ST_RD_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_ADDR: begin
        if (s_r_rdy) begin
          state_d = ST_RD_DATA;
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (s_re_valid) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_next_s;
        end else begin
          state_d = ST_RD_DATA;
        end
      end
      ST_WR: begin
        if (s_w_rdy) begin
          state_d = ST_IDLE;
          ptr_d   = ptr_next_s;
        end else begin
          state_d = ST_WR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, grant and pointer registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Phase decode is masked by reset so downstream requests drop immediately.
  always_comb begin
    rd_addr_s = !reset && (state_q == ST_RD_ADDR);
    rd_data_s = !reset && (state_q == ST_RD_DATA);
    wr_s      = !reset && (state_q == ST_WR);
  end

  // Downstream mux from the granted slice; handshakes routed back to the granted master.
  always_comb begin
    int sel;
    sel        = int'(gnt_q);
    s_r_req    = rd_addr_s;
    s_w_req    = wr_s;
    s_r_addr   = m_r_addr[sel*ADDR_W +: ADDR_W];
    s_r_type   = m_r_type[sel*TYPE_W +: TYPE_W];
    s_w_addr   = m_w_addr[sel*ADDR_W +: ADDR_W];
    s_w_data   = m_w_data[sel*DATA_W +: DATA_W];
    s_w_type   = m_w_type[sel*TYPE_W +: TYPE_W];
    s_w_strb   = m_w_strb[sel*STRB_W +: STRB_W];
    m_re_data  = s_re_data;
    m_r_rdy    = '0;
    m_re_valid = '0;
    m_w_rdy    = '0;
    if (rd_addr_s) begin
      m_r_rdy[gnt_q] = s_r_rdy;
    end else begin
      m_r_rdy = '0;
    end
    if (rd_data_s) begin
      m_re_valid[gnt_q] = s_re_valid;
    end else begin
      m_re_valid = '0;
    end
    if (wr_s) begin
      m_w_rdy[gnt_q] = s_w_rdy;
    end else begin
      m_w_rdy = '0;
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter_n.sv
// Directed bench for sram_bus_arbiter_n: one round-robin and one fixed-priority
// instance share all inputs; each scenario task checks hand-computed values.
module tb_sram_bus_arbiter_n;

  localparam int NM = 3;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int TW = 6;
  localparam int SW = 16;

  logic clock;
  logic reset;
  logic [NM-1:0]    m_r_req, m_w_req;
  logic [NM*AW-1:0] m_r_addr, m_w_addr;
  logic [NM*TW-1:0] m_r_type, m_w_type;
  logic [NM*DW-1:0] m_w_data;
  logic [NM*SW-1:0] m_w_strb;
  logic             s_r_rdy, s_re_valid, s_w_rdy;
  logic [DW-1:0]    s_re_data;

  logic [NM-1:0] m_r_rdy, m_re_valid, m_w_rdy;
  logic [DW-1:0] m_re_data, s_w_data;
  logic          s_r_req, s_w_req;
  logic [AW-1:0] s_r_addr, s_w_addr;
  logic [TW-1:0] s_r_type, s_w_type;
  logic [SW-1:0] s_w_strb;

  logic [NM-1:0] fx_m_r_rdy, fx_m_re_valid, fx_m_w_rdy;
  logic [DW-1:0] fx_m_re_data, fx_s_w_data;
  logic          fx_s_r_req, fx_s_w_req;
  logic [AW-1:0] fx_s_r_addr, fx_s_w_addr;
  logic [TW-1:0] fx_s_r_type, fx_s_w_type;
  logic [SW-1:0] fx_s_w_strb;

  int checks   = 0;
  int failures = 0;

  sram_bus_arbiter_n #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW),
                       .STRB_W(SW), .RR_MODE(1)) dut (
    .clock(clock), .reset(reset),
    .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type),
    .m_r_rdy(m_r_rdy), .m_re_valid(m_re_valid), .m_re_data(m_re_data),
    .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
    .m_w_type(m_w_type), .m_w_strb(m_w_strb), .m_w_rdy(m_w_rdy),
    .s_r_req(s_r_req), .s_r_addr(s_r_addr), .s_r_type(s_r_type), .s_r_rdy(s_r_rdy),
    .s_re_valid(s_re_valid), .s_re_data(s_re_data),
    .s_w_req(s_w_req), .s_w_addr(s_w_addr), .s_w_data(s_w_data),
    .s_w_type(s_w_type), .s_w_strb(s_w_strb), .s_w_rdy(s_w_rdy)
  );

  sram_bus_arbiter_n #(.NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TYPE_W(TW),
                       .STRB_W(SW), .RR_MODE(0)) dut_fx (
    .clock(clock), .reset(reset),
    .m_r_req(m_r_req), .m_r_addr(m_r_addr), .m_r_type(m_r_type),
    .m_r_rdy(fx_m_r_rdy), .m_re_valid(fx_m_re_valid), .m_re_data(fx_m_re_data),
    .m_w_req(m_w_req), .m_w_addr(m_w_addr), .m_w_data(m_w_data),
    .m_w_type(m_w_type), .m_w_strb(m_w_strb), .m_w_rdy(fx_m_w_rdy),
    .s_r_req(fx_s_r_req), .s_r_addr(fx_s_r_addr), .s_r_type(fx_s_r_type), .s_r_rdy(s_r_rdy),
    .s_re_valid(s_re_valid), .s_re_data(s_re_data),
    .s_w_req(fx_s_w_req), .s_w_addr(fx_s_w_addr), .s_w_data(fx_s_w_data),
    .s_w_type(fx_s_w_type), .s_w_strb(fx_s_w_strb), .s_w_rdy(s_w_rdy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_r_req = '0; m_w_req = '0; m_r_addr = '0; m_w_addr = '0;
    m_r_type = '0; m_w_type = '0; m_w_data = '0; m_w_strb = '0;
    s_r_rdy = 1'b0; s_re_valid = 1'b0; s_w_rdy = 1'b0; s_re_data = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    m_r_addr[0 +: AW] = 32'h0000_1234;
    m_r_addr[AW +: AW] = 32'h0000_5678;
    #1;
    checks++; if (s_r_req !== 1'b0) begin failures++; $display("FAIL reset_s_r_req got %0b exp 0", s_r_req); end
    checks++; if (s_w_req !== 1'b0) begin failures++; $display("FAIL reset_s_w_req got %0b exp 0", s_w_req); end
    checks++; if ({m_r_rdy, m_re_valid, m_w_rdy} !== 9'd0) begin failures++; $display("FAIL reset_m_rdy got %0h exp 0", {m_r_rdy, m_re_valid, m_w_rdy}); end
    checks++; if (s_r_addr !== 32'h0000_1234) begin failures++; $display("FAIL reset_addr_slice0 got %0h exp 1234", s_r_addr); end
  endtask

  task automatic test_read_single();
    logic [DW-1:0] rdata;
    rdata = {32{8'hA5}};
    do_reset();
    m_r_req[1] = 1'b1;
    m_r_addr[AW +: AW] = 32'h8000_0040;
    m_r_type[TW +: TW] = 6'h05;
    #1;
    checks++; if (s_r_req !== 1'b0) begin failures++; $display("FAIL rd_idle_req got %0b exp 0", s_r_req); end
    tick(); #1;
    checks++; if (s_r_req !== 1'b1) begin failures++; $display("FAIL rd_grant_req got %0b exp 1", s_r_req); end
    checks++; if (s_r_addr !== 32'h8000_0040) begin failures++; $display("FAIL rd_addr got %0h exp 80000040", s_r_addr); end
    checks++; if (s_r_type !== 6'h05) begin failures++; $display("FAIL rd_type got %0h exp 05", s_r_type); end
    checks++; if (m_r_rdy !== 3'b000) begin failures++; $display("FAIL rd_rdy_early got %0b exp 000", m_r_rdy); end
    tick(); s_r_rdy = 1'b1; #1;
    checks++; if (m_r_rdy !== 3'b010) begin failures++; $display("FAIL rd_rdy got %0b exp 010", m_r_rdy); end
    tick(); m_r_req = '0; s_r_rdy = 1'b0; #1;
    checks++; if (s_r_req !== 1'b0) begin failures++; $display("FAIL rd_data_req got %0b exp 0", s_r_req); end
    checks++; if (m_re_valid !== 3'b000) begin failures++; $display("FAIL rd_valid_early got %0b exp 000", m_re_valid); end
    tick(); tick(); s_re_valid = 1'b1; s_re_data = rdata; #1;
    checks++; if (m_re_valid !== 3'b010) begin failures++; $display("FAIL rd_valid got %0b exp 010", m_re_valid); end
    checks++; if (m_re_data !== rdata) begin failures++; $display("FAIL rd_data got %0h exp %0h", m_re_data, rdata); end
    tick(); s_re_valid = 1'b0; #1;
    checks++; if ({s_r_req, s_w_req, m_re_valid} !== 5'd0) begin failures++; $display("FAIL rd_back_idle got %0b exp 0", {s_r_req, s_w_req, m_re_valid}); end
  endtask

  task automatic test_round_robin();
    int exp_g[4] = '{0, 1, 2, 0};
    do_reset();
    for (int i = 0; i < NM; i++) m_r_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 256);
    m_r_req = 3'b111; s_r_rdy = 1'b1; s_re_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (s_r_req !== 1'b0) begin failures++; $display("FAIL rr_idle_gap[%0d] got %0b exp 0", n, s_r_req); end
      tick(); #1;
      checks++; if (s_r_addr !== 32'h1000_0000 + 32'(exp_g[n] * 256)) begin failures++; $display("FAIL rr_grant_addr[%0d] got %0h exp master %0d", n, s_r_addr, exp_g[n]); end
      checks++; if (m_r_rdy !== (3'b001 << exp_g[n])) begin failures++; $display("FAIL rr_rdy[%0d] got %0b exp master %0d", n, m_r_rdy, exp_g[n]); end
      tick(); #1;
      checks++; if (m_re_valid !== (3'b001 << exp_g[n])) begin failures++; $display("FAIL rr_valid[%0d] got %0b exp master %0d", n, m_re_valid, exp_g[n]); end
      tick();
    end
    m_r_req = '0; s_r_rdy = 1'b0; s_re_valid = 1'b0;
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < NM; i++) m_r_addr[i*AW +: AW] = 32'h1000_0000 + 32'(i * 256);
    m_r_req = 3'b111; s_r_rdy = 1'b1; s_re_valid = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1;
      checks++; if (fx_s_r_req !== 1'b0) begin failures++; $display("FAIL fx_idle_gap[%0d] got %0b exp 0", n, fx_s_r_req); end
      tick(); #1;
      checks++; if (fx_s_r_addr !== 32'h1000_0000) begin failures++; $display("FAIL fx_grant_addr[%0d] got %0h exp 10000000", n, fx_s_r_addr); end
      checks++; if (fx_m_r_rdy !== 3'b001) begin failures++; $display("FAIL fx_rdy[%0d] got %0b exp 001", n, fx_m_r_rdy); end
      tick(); #1;
      checks++; if (fx_m_re_valid !== 3'b001) begin failures++; $display("FAIL fx_valid[%0d] got %0b exp 001", n, fx_m_re_valid); end
      tick();
    end
    m_r_req = '0; s_r_rdy = 1'b0; s_re_valid = 1'b0;
  endtask

  task automatic test_write_first();
    logic [DW-1:0] wdata;
    wdata = {8{32'hDEAD_BEEF}};
    do_reset();
    m_w_req[1] = 1'b1; m_r_req[1] = 1'b1;
    m_w_addr[AW +: AW] = 32'h2000_0080;
    m_r_addr[AW +: AW] = 32'h2000_00C0;
    m_w_data[DW +: DW] = wdata;
    m_w_type[TW +: TW] = 6'h11;
    m_w_strb[SW +: SW] = 16'hFFFF;
    #1;
    checks++; if (s_w_req !== 1'b0) begin failures++; $display("FAIL wf_idle got %0b exp 0", s_w_req); end
    tick(); #1;
    checks++; if ({s_w_req, s_r_req} !== 2'b10) begin failures++; $display("FAIL wf_write_first got %0b exp 10", {s_w_req, s_r_req}); end
    checks++; if (s_w_addr !== 32'h2000_0080) begin failures++; $display("FAIL wf_addr got %0h exp 20000080", s_w_addr); end
    checks++; if (s_w_data !== wdata) begin failures++; $display("FAIL wf_data got %0h exp %0h", s_w_data, wdata); end
    checks++; if (s_w_strb !== 16'hFFFF) begin failures++; $display("FAIL wf_strb got %0h exp ffff", s_w_strb); end
    checks++; if (s_w_type !== 6'h11) begin failures++; $display("FAIL wf_type got %0h exp 11", s_w_type); end
    checks++; if (m_w_rdy !== 3'b000) begin failures++; $display("FAIL wf_rdy_early got %0b exp 000", m_w_rdy); end
    tick(); s_w_rdy = 1'b1; #1;
    checks++; if (m_w_rdy !== 3'b010) begin failures++; $display("FAIL wf_rdy got %0b exp 010", m_w_rdy); end
    tick(); m_w_req = '0; s_w_rdy = 1'b0; #1;
    checks++; if ({s_w_req, s_r_req} !== 2'b00) begin failures++; $display("FAIL wf_gap got %0b exp 00", {s_w_req, s_r_req}); end
    tick(); s_r_rdy = 1'b1; #1;
    checks++; if (s_r_req !== 1'b1 || s_r_addr !== 32'h2000_00C0) begin failures++; $display("FAIL wf_read_after got req %0b addr %0h exp 1 200000c0", s_r_req, s_r_addr); end
    checks++; if (m_r_rdy !== 3'b010) begin failures++; $display("FAIL wf_read_rdy got %0b exp 010", m_r_rdy); end
    tick(); m_r_req = '0; s_r_rdy = 1'b0; s_re_valid = 1'b1; #1;
    checks++; if (m_re_valid !== 3'b010) begin failures++; $display("FAIL wf_read_valid got %0b exp 010", m_re_valid); end
    tick(); s_re_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m_r_addr[0 +: AW] = 32'h0000_1234;
    m_r_addr[2*AW +: AW] = 32'h3000_0000;
    m_r_req[2] = 1'b1;
    tick(); s_r_rdy = 1'b1; #1;
    checks++; if (m_r_rdy !== 3'b100) begin failures++; $display("FAIL rm_rdy got %0b exp 100", m_r_rdy); end
    tick(); m_r_req = '0; s_r_rdy = 1'b0; reset = 1'b1; #1;
    checks++; if (m_re_valid !== 3'b000) begin failures++; $display("FAIL rm_valid_in_reset got %0b exp 000", m_re_valid); end
    tick(); reset = 1'b0; #1;
    checks++; if ({s_r_req, s_w_req, m_r_rdy, m_w_rdy} !== 8'd0) begin failures++; $display("FAIL rm_outputs got %0b exp 0", {s_r_req, s_w_req, m_r_rdy, m_w_rdy}); end
    checks++; if (s_r_addr !== 32'h0000_1234) begin failures++; $display("FAIL rm_gnt_slice0 got %0h exp 1234", s_r_addr); end
    s_re_valid = 1'b1; #1;
    checks++; if (m_re_valid !== 3'b000) begin failures++; $display("FAIL rm_stray_valid got %0b exp 000", m_re_valid); end
    tick(); s_re_valid = 1'b0;
    m_r_addr[AW +: AW] = 32'h4000_0000; m_r_req[1] = 1'b1;
    tick(); #1;
    checks++; if (s_r_req !== 1'b1) begin failures++; $display("FAIL rm2_req got %0b exp 1", s_r_req); end
    reset = 1'b1; s_r_rdy = 1'b1; #1;
    checks++; if ({s_r_req, m_r_rdy} !== 4'd0) begin failures++; $display("FAIL rm2_same_cycle_drop got %0b exp 0", {s_r_req, m_r_rdy}); end
    tick(); reset = 1'b0; m_r_req = '0; s_r_rdy = 1'b0; #1;
    checks++; if (s_r_req !== 1'b0) begin failures++; $display("FAIL rm2_idle got %0b exp 0", s_r_req); end
  endtask

  task automatic test_spurious();
    do_reset();
    s_w_rdy = 1'b1; s_r_rdy = 1'b1; #1;
    checks++; if (m_w_rdy !== 3'b000 || fx_m_w_rdy !== 3'b000) begin failures++; $display("FAIL sp_wrdy got %0b/%0b exp 000", m_w_rdy, fx_m_w_rdy); end
    checks++; if (m_r_rdy !== 3'b000) begin failures++; $display("FAIL sp_rrdy got %0b exp 000", m_r_rdy); end
    tick(); #1;
    checks++; if ({s_w_req, s_r_req, m_w_rdy} !== 5'd0) begin failures++; $display("FAIL sp_stay_idle got %0b exp 0", {s_w_req, s_r_req, m_w_rdy}); end
    s_w_rdy = 1'b0; s_r_rdy = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_read_single();
    test_round_robin();
    test_fixed_priority();
    test_write_first();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
